tt_um_logic_unit: RTL and testbench



---
 rtl/tt_logic_pkg.sv | 30 +++
 rtl/logic_op_unit.sv | 29 ++
 rtl/tt_um_logic_unit.sv | 102 ++++++++++
 tb/tb_tt_um_logic_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_logic_pkg.sv
// Shared encodings for the logic unit: op-select values and output bit positions.
package tt_logic_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    // uio_in control bit positions
    localparam int unsigned STROBE_BIT = 3;
    localparam int unsigned ACC_BIT    = 4;
    localparam int unsigned CLEAR_BIT  = 5;

    // uo_out bit positions
    localparam int unsigned VALID_BIT  = 4;
    localparam int unsigned AND_BIT    = 5;
    localparam int unsigned OR_BIT     = 6;
    localparam int unsigned XOR_BIT    = 7;

    // uio_out counter position and fixed output enables
    localparam int unsigned CNT_LSB    = 6;
    localparam logic [7:0]  UIO_OE_VAL = 8'b1100_0000;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise operator selected by op.
module logic_op_unit
    import tt_logic_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  op_e              op,
    output logic [WIDTH-1:0] z
);

    // Select the bitwise function of x and y
    always_comb begin
        z = '0;
        case (op)
            OP_AND:  z = x & y;
            OP_OR:   z = x | y;
            OP_XOR:  z = x ^ y;
            OP_NAND: z = ~(x & y);
            OP_NOR:  z = ~(x | y);
            OP_XNOR: z = ~(x ^ y);
            OP_ANDN: z = x & ~y;
            OP_PASS: z = x;
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/tt_um_logic_unit.sv
// Strobe-loaded logic unit: synchronised load strobe, optional accumulate,
// registered result with reduction flags and a 2-bit load counter.
module tt_um_logic_unit
    import tt_logic_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic [1:0]       strobe_cnt;
    logic             sync1;
    logic             sync2;
    logic             sync3;
    logic             rise;
    logic             acc_mode;
    logic             clear;

    assign opa      = ui_in[WIDTH-1:0];
    assign opb      = ui_in[4+WIDTH-1:4];
    assign acc_mode = uio_in[ACC_BIT];
    assign clear    = uio_in[CLEAR_BIT];
    assign rise     = sync2 & ~sync3;

    // Accumulate mode feeds the held result back as the first operand
    assign x = acc_mode ? result : opa;
    assign y = acc_mode ? opa : opb;

    logic_op_unit #(.WIDTH(WIDTH)) u_op (
        .x  (x),
        .y  (y),
        .op (op_e'(uio_in[2:0])),
        .z  (z)
    );

    // Strobe synchroniser, edge detector and result/valid/counter registers.
    // The synchroniser keeps shifting while ena is low so that an edge
    // arriving then is consumed and lost rather than replayed later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            result     <= '0;
            out_valid  <= 1'b0;
            strobe_cnt <= '0;
        end else begin
            sync1 <= uio_in[STROBE_BIT];
            sync2 <= sync1;
            sync3 <= sync2;
            if (ena) begin
                if (clear) begin
                    result     <= '0;
                    out_valid  <= 1'b0;
                    strobe_cnt <= '0;
                end else if (rise) begin
                    result     <= z;
                    out_valid  <= 1'b1;
                    strobe_cnt <= strobe_cnt + 2'd1;
                end else begin
                    out_valid  <= 1'b0;
                end
            end
        end
    end

    // Assemble result, valid and reduction flags over the WIDTH result bits
    always_comb begin
        uo_out                = '0;
        uo_out[WIDTH-1:0]     = result;
        uo_out[VALID_BIT]     = out_valid;
        uo_out[AND_BIT]       = &result;
        uo_out[OR_BIT]        = |result;
        uo_out[XOR_BIT]       = ^result;
    end

    // Bidirectional pins: only the counter is driven out
    always_comb begin
        uio_out                     = '0;
        uio_out[CNT_LSB+1:CNT_LSB]  = strobe_cnt;
    end

    assign uio_oe = UIO_OE_VAL;

    logic unused_ok;
    assign unused_ok = &{1'b0, ui_in, uio_in[7:6]};

endmodule

// File: tb/tb_tt_um_logic_unit.sv
// Directed bench for tt_um_logic_unit (WIDTH=4 and WIDTH=2 builds).
module tb_tt_um_logic_unit;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic [7:0] ui_in2;
    logic [7:0] uio_in2;
    logic [7:0] uo_out2;
    logic [7:0] uio_out2;
    logic [7:0] uio_oe2;

    int total;
    int bad;

    tt_um_logic_unit #(.WIDTH(4)) dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    tt_um_logic_unit #(.WIDTH(2)) dut2 (
        .ui_in   (ui_in2),
        .uo_out  (uo_out2),
        .uio_in  (uio_in2),
        .uio_out (uio_out2),
        .uio_oe  (uio_oe2),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected uo_out for a 4-bit result
    function automatic logic [7:0] uo_exp(input logic [3:0] r, input logic v);
        return {^r, |r, &r, v, r};
    endfunction

    // one-cycle strobe; returns with outputs just after the load edge
    task automatic pulse();
        uio_in[3] = 1'b1;
        step();
        uio_in[3] = 1'b0;
        step();
        step();
    endtask

    logic [3:0] sweep_exp [8];
    logic [3:0] acc_exp   [4];
    logic [3:0] acc_a     [4];
    int         vcount;
    logic [1:0] cnt;

    initial begin
        total = 0;
        bad   = 0;
        sweep_exp = '{4'h8, 4'hE, 4'h6, 4'h7, 4'h1, 4'h9, 4'h4, 4'hC};
        acc_a     = '{4'h1, 4'h2, 4'h4, 4'h8};
        acc_exp   = '{4'h1, 4'h3, 4'h7, 4'hF};

        rst_n   = 1'b0;
        ena     = 1'b1;
        ui_in   = 8'h00;
        uio_in  = 8'h00;
        ui_in2  = 8'h00;
        uio_in2 = 8'h00;
        #2;
        chk("reset_uo", uo_out, 8'h00);
        chk("reset_uio_out", uio_out, 8'h00);
        chk("reset_uio_oe", uio_oe, 8'hC0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // single AND load: A=C, B=A
        ui_in  = 8'hAC;
        uio_in = 8'h00;
        uio_in[3] = 1'b1;
        step();
        uio_in[3] = 1'b0;
        step();
        chk("and_not_yet", uo_out, 8'h00);
        step();
        chk("and_load_uo", uo_out, 8'hD8);
        chk("and_load_cnt", uio_out, 8'h40);
        step();
        chk("and_valid_drop", uo_out, 8'hC8);

        // op sweep, mode 0
        cnt = 2'd1;
        for (int i = 0; i < 8; i++) begin
            uio_in[2:0] = i[2:0];
            pulse();
            cnt = cnt + 2'd1;
            chk($sformatf("sweep_op%0d", i), uo_out, uo_exp(sweep_exp[i], 1'b1));
            chk($sformatf("sweep_cnt%0d", i), uio_out, {cnt, 6'b0});
            step();
        end

        // op change between loads has no effect on the held result (last was PASS -> C)
        uio_in[2:0] = 3'd4;
        step();
        step();
        chk("op_change_hold", uo_out, uo_exp(4'hC, 1'b0));

        // clear, then accumulate OR of 1,2,4,8
        uio_in[5] = 1'b1;
        step();
        uio_in[5] = 1'b0;
        chk("clear_uo", uo_out, 8'h00);
        chk("clear_cnt", uio_out, 8'h00);
        uio_in[2:0] = 3'd1;
        uio_in[4]   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ui_in = {4'h5, acc_a[i]};
            pulse();
            chk($sformatf("acc_%0d", i), uo_out, uo_exp(acc_exp[i], 1'b1));
            step();
        end
        chk("acc_last_uo", uo_out, 8'h6F);
        chk("acc_cnt_wrap", uio_out, 8'h00);
        uio_in[4] = 1'b0;

        // held strobe: one load only
        ui_in       = 8'hAC;
        uio_in[2:0] = 3'd2;
        uio_in[3]   = 1'b1;
        vcount      = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (uo_out[4]) vcount++;
        end
        uio_in[3] = 1'b0;
        chk("held_one_pulse", vcount[7:0], 8'd1);
        chk("held_result", uo_out, uo_exp(4'h6, 1'b0));
        chk("held_cnt", uio_out, 8'h40);
        step();
        step();
        step();

        // clear coincident with the load edge wins
        uio_in[3] = 1'b1;
        step();
        uio_in[3] = 1'b0;
        step();
        uio_in[5] = 1'b1;
        step();
        uio_in[5] = 1'b0;
        chk("clr_vs_load_uo", uo_out, 8'h00);
        chk("clr_vs_load_cnt", uio_out, 8'h00);
        step();
        chk("clr_vs_load_after", uo_out, 8'h00);

        // ena low at load edge: edge lost
        uio_in[2:0] = 3'd7;
        uio_in[3]   = 1'b1;
        step();
        uio_in[3] = 1'b0;
        step();
        ena = 1'b0;
        step();
        ena = 1'b1;
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (uo_out[4]) vcount++;
        end
        chk("ena_lost_pulses", vcount[7:0], 8'd0);
        chk("ena_lost_uo", uo_out, 8'h00);

        // load something, then reset during an in-flight strobe
        pulse();
        chk("pre_reset_uo", uo_out, uo_exp(4'hC, 1'b1));
        step();
        step();
        uio_in[3] = 1'b1;
        step();
        uio_in[3] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async_uo", uo_out, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (uo_out[4]) vcount++;
        end
        chk("rst_no_valid", vcount[7:0], 8'd0);
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio_out", uio_out, 8'h00);
        chk("rst_uio_oe", uio_oe, 8'hC0);

        // WIDTH=2 build: A=11, B=01, XOR -> 10
        ui_in2  = 8'b0001_0011;
        uio_in2 = 8'h02;
        uio_in2[3] = 1'b1;
        step();
        uio_in2[3] = 1'b0;
        step();
        step();
        chk("w2_uo", uo_out2, 8'hD2);
        chk("w2_cnt", uio_out2, 8'h40);
        chk("w2_oe", uio_oe2, 8'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
